op_sequencer: RTL

OP_SEQUENCER -- requirements
Module: op_sequencer

---
 rtl/op_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/op_sequencer.sv
// Control-code sequencer: walks the enabled bits of a latched mask from low to high,
// presenting each code index for HOLD cycles, with pause, abort and optional wrap.
module op_sequencer #(
    parameter int HOLD = 2,
    parameter int LOOP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [7:0] mask,
    output logic [2:0] c,
    output logic       c_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] code_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] c_q, c_d;
    logic       c_valid_q, c_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] code_cnt_q, code_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] mask_q, mask_d;

    logic [7:0] higher_bits;
    logic       has_higher;
    logic [2:0] next_idx;
    logic [2:0] first_idx;
    logic [3:0] cnt_inc;
    logic       do_step;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    // Enabled codes strictly above the one currently presented.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_higher
            assign higher_bits[gi] = mask_q[gi] && (3'(gi) > c_q);
        end
    endgenerate

    assign has_higher = |higher_bits;
    assign next_idx   = lowest_bit(higher_bits);
    assign first_idx  = lowest_bit(mask_q);
    assign cnt_inc    = (code_cnt_q == 4'd15) ? 4'd15 : code_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        c_valid_d  = c_valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        code_cnt_d = code_cnt_q;
        hold_cnt_d = hold_cnt_q;
        mask_d     = mask_q;
        do_step    = 1'b0;

        case (state_q)
            S_IDLE: begin
                c_valid_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                if (!abort && start) begin
                    if (mask != 8'd0) begin
                        state_d    = S_RUN;
                        mask_d     = mask;
                        c_d        = lowest_bit(mask);
                        hold_cnt_d = 8'd0;
                        code_cnt_d = 4'd1;
                        c_valid_d  = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        code_cnt_d = 4'd0;
                        done_d     = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    c_d        = 3'd0;
                    c_valid_d  = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                    hold_cnt_d = 8'd0;
                end else if (pause) begin
                    state_d   = S_PAUSE;
                    c_valid_d = 1'b0;
                end else begin
                    do_step = 1'b1;
                end
            end
            S_PAUSE: begin
                // The last valid cycle before the pause was never stepped; the
                // resume edge takes that step so each code keeps exactly HOLD valid cycles.
                if (abort) begin
                    state_d    = S_IDLE;
                    c_d        = 3'd0;
                    c_valid_d  = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                    hold_cnt_d = 8'd0;
                end else if (!pause) begin
                    state_d   = S_RUN;
                    c_valid_d = 1'b1;
                    do_step   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                if (abort) c_d = 3'd0;
            end
            default: begin
                state_d   = S_IDLE;
                c_valid_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
            end
        endcase

        if (do_step) begin
            if (hold_cnt_q == HOLD_LAST) begin
                hold_cnt_d = 8'd0;
                if (has_higher) begin
                    c_d        = next_idx;
                    code_cnt_d = cnt_inc;
                end else if (LOOP != 0) begin
                    c_d        = first_idx;
                    code_cnt_d = cnt_inc;
                end else begin
                    state_d   = S_DONE;
                    c_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end else begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            c_q        <= 3'd0;
            c_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            code_cnt_q <= 4'd0;
            hold_cnt_q <= 8'd0;
            mask_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            c_valid_q  <= c_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            code_cnt_q <= code_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
        end
    end

    assign c        = c_q;
    assign c_valid  = c_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign code_cnt = code_cnt_q;

endmodule
